// File: rtl/usb_msg_streamer.sv
// Text-message byte source for the usb_uart pipeline, with optional hex
// sequence prefix and host echo. MSG_INIT holds the text, first char in MSB.
module usb_msg_streamer #(
  parameter int                   MSG_LEN     = 16,
  parameter logic [8*MSG_LEN-1:0] MSG_INIT    = "Hello from FPGA\n",
  parameter int                   MODE        = 0,
  parameter int                   DELAY_WIDTH = 26,
  parameter int                   SEQ_DIGITS  = 4,
  parameter int                   ECHO        = 1
) (
  input  logic        clk_48mhz,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        trigger,
  output logic [7:0]  uart_in_data,
  output logic        uart_in_valid,
  input  logic        uart_in_ready,
  input  logic [7:0]  uart_out_data,
  input  logic        uart_out_valid,
  output logic        uart_out_ready,
  output logic        busy,
  output logic [15:0] msg_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PREFIX = 3'd1;
  localparam logic [2:0] S_MSG    = 3'd2;
  localparam logic [2:0] S_ECHO   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam int SH = (SEQ_DIGITS > 0) ? 4 * (4 - SEQ_DIGITS) : 0;

  logic [1:0]             rst_sync;
  logic                   rst_n;
  logic [2:0]             state;
  logic [2:0]             ret_state;
  logic [DELAY_WIDTH-1:0] dcnt;
  logic [2:0]             tsync;
  logic                   pending;
  logic [8:0]             idx;
  logic [15:0]            snap;
  logic [15:0]            seq0;
  logic                   idle_or_wait;
  logic                   trig_edge;
  logic                   start_now;
  logic                   in_xfer;
  logic                   out_xfer;
  logic                   wait_run;
  logic                   dcnt_full;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] rom(input logic [8:0] i);
    logic [8*MSG_LEN-1:0] t;
    t = MSG_INIT >> (8 * (MSG_LEN - 1 - int'(i)));
    return t[7:0];
  endfunction

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign idle_or_wait = (state == S_IDLE) || (state == S_WAIT);
  assign trig_edge    = tsync[1] & ~tsync[2];
  assign start_now    = (MODE == 0) ? (enable && state == S_IDLE)
                                    : (enable && pending && idle_or_wait);
  // a message start wins over a host byte arriving in the same cycle
  assign uart_out_ready = (ECHO != 0) && rst_n && idle_or_wait && !start_now;
  assign busy      = (state == S_PREFIX) || (state == S_MSG);
  assign in_xfer   = uart_in_valid & uart_in_ready;
  assign out_xfer  = uart_out_valid & uart_out_ready;
  assign dcnt_full = &dcnt;
  assign wait_run  = (state == S_WAIT) ||
                     (state == S_ECHO && ret_state == S_WAIT);
  assign seq0      = msg_count << SH;

  always_ff @(posedge clk_48mhz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ret_state     <= S_IDLE;
      dcnt          <= '0;
      tsync         <= '0;
      pending       <= 1'b0;
      idx           <= '0;
      snap          <= '0;
      uart_in_data  <= '0;
      uart_in_valid <= 1'b0;
      msg_count     <= '0;
    end else begin
      tsync <= {tsync[1:0], trigger};
      if (start_now)      pending <= 1'b0;
      else if (trig_edge) pending <= 1'b1;
      if (wait_run && !dcnt_full) dcnt <= dcnt + 1'b1;
      case (state)
        S_IDLE, S_WAIT: begin
          if (start_now) begin
            uart_in_valid <= 1'b1;
            idx           <= 9'd1;
            if (SEQ_DIGITS > 0) begin
              state        <= S_PREFIX;
              uart_in_data <= hex(seq0[15:12]);
              snap         <= seq0 << 4;
            end else begin
              state        <= S_MSG;
              uart_in_data <= rom(9'd0);
            end
          end else if (out_xfer) begin
            state         <= S_ECHO;
            ret_state     <= state;
            uart_in_data  <= uart_out_data;
            uart_in_valid <= 1'b1;
          end else if (state == S_WAIT && dcnt_full) begin
            state <= S_IDLE;
          end
        end
        S_PREFIX: begin
          if (in_xfer) begin
            if (idx == 9'(SEQ_DIGITS)) begin
              state        <= S_MSG;
              uart_in_data <= rom(9'd0);
              idx          <= 9'd1;
            end else begin
              uart_in_data <= hex(snap[15:12]);
              snap         <= snap << 4;
              idx          <= idx + 9'd1;
            end
          end
        end
        S_MSG: begin
          if (in_xfer) begin
            if (idx == 9'(MSG_LEN)) begin
              uart_in_valid <= 1'b0;
              msg_count     <= msg_count + 16'd1;
              idx           <= '0;
              if (MODE == 0) begin
                state <= S_WAIT;
                dcnt  <= '0;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              uart_in_data <= rom(idx);
              idx          <= idx + 9'd1;
            end
          end
        end
        S_ECHO: begin
          if (in_xfer) begin
            uart_in_valid <= 1'b0;
            state         <= ret_state;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
